// File: rtl/dmem_responder.sv
// dmem_responder
//   Single-clock data-memory responder for the MEM stage. Accepts one
//   load/store at a time over a valid/ready channel, waits WAIT_STATES
//   extra cycles to model slow memory, then emits a one-cycle response.
//
// Parameters
//   ADDR_W      word-address width
//   DEPTH       implemented 32-bit words (<= 2**ADDR_W)
//   WAIT_STATES extra cycles between acceptance and response (0..15)
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   req_valid/req_ready     request handshake
//   req_we                  1 = store, 0 = load
//   req_addr                word address
//   req_wdata, req_wstrb    store data and byte enables
//   resp_valid              one-cycle pulse per accepted request
//   resp_rdata              load data (0 for stores and errors), held
//   resp_err                address >= DEPTH, qualified by resp_valid
//   stall                   req_valid & ~req_ready
module dmem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wstrb,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              stall
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
  } req_t;

  localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t      state;
  logic [3:0]  cnt;
  req_t        lat;
  logic [31:0] mem [DEPTH];

  logic        accept;
  req_t        rsp_src;
  logic        rsp_hit;
  logic [31:0] rsp_data;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {{(32-ADDR_W){1'b0}}, a} < 32'(DEPTH);
  endfunction

  // Gating with rst_n keeps ready low for the whole reset window, including
  // before the first edge has put the FSM into IDLE.
  assign req_ready = rst_n && (state != BUSY);
  assign accept    = req_valid && req_ready;
  assign stall     = req_valid && !req_ready;

  // With no wait states the response is formed on the acceptance edge, so
  // the live request is the source; otherwise it is the latched copy.
  always_comb begin
    rsp_src  = (state == BUSY) ? lat : req_t'{we: req_we, addr: req_addr};
    rsp_hit  = in_range(rsp_src.addr);
    rsp_data = 32'd0;
    if (!rsp_src.we && rsp_hit)
      rsp_data = mem[rsp_src.addr];
  end

  // Stores commit at acceptance, so a load accepted in the following RESP
  // cycle already sees them. Array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept && req_we && in_range(req_addr)) begin
      for (int b = 0; b < 4; b++)
        if (req_wstrb[b])
          mem[req_addr][8*b +: 8] <= req_wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      lat        <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      unique case (state)
        IDLE, RESP: begin
          if (accept) begin
            lat.we   <= req_we;
            lat.addr <= req_addr;
            if (WAIT_STATES > 0) begin
              state <= BUSY;
              cnt   <= WS_INIT;
            end else begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= rsp_data;
              resp_err   <= !rsp_hit;
            end
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= rsp_data;
            resp_err   <= !rsp_hit;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [1:0]       req_valid, req_ready, req_we, resp_valid, resp_err, stall;
  logic [1:0][7:0]  req_addr;
  logic [1:0][31:0] req_wdata, resp_rdata;
  logic [1:0][3:0]  req_wstrb;

  // Instance 0: no wait states, shallow array (out-of-range coverage).
  dmem_responder #(.ADDR_W(8), .DEPTH(200), .WAIT_STATES(0)) u0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wstrb(req_wstrb[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
    .stall(stall[0]));

  // Instance 1: three wait states, full array.
  dmem_responder #(.ADDR_W(8), .DEPTH(256), .WAIT_STATES(3)) u1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wstrb(req_wstrb[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
    .stall(stall[1]));

  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] model [2][256];
  int          n_cmp = 0;
  int          n_err = 0;
  int          stall0_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input int i, input logic [31:0] d, input logic e);
    if (i == 0) q0.push_back({d, e});
    else        q1.push_back({d, e});
  endtask

  // Drive one request, wait (bounded) for acceptance, record the expected
  // response from the bench's own memory model, then drop valid.
  task automatic send(input int i, input logic we, input logic [7:0] a,
                      input logic [31:0] wd, input logic [3:0] st);
    int   c;
    int   depth;
    logic hit;
    c     = 0;
    depth = (i == 0) ? 200 : 256;
    hit   = (int'(a) < depth);
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    req_addr[i]  = a;
    req_wdata[i] = wd;
    req_wstrb[i] = st;
    @(negedge clk);
    while (!req_ready[i] && c < 50) begin
      @(negedge clk);
      c++;
    end
    if (c >= 50) chk("accept_timeout", 32'(req_ready[i]), 32'd1);
    if (we) begin
      if (hit)
        for (int b = 0; b < 4; b++)
          if (st[b]) model[i][a][8*b +: 8] = wd[8*b +: 8];
      push(i, 32'd0, !hit);
    end else begin
      push(i, hit ? model[i][a] : 32'd0, !hit);
    end
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
  endtask

  // Scoreboard: every response pulse pops one expected entry.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (resp_valid[i]) begin
        if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
          chk($sformatf("unexpected_resp%0d", i), 32'(resp_valid[i]), 32'd0);
        end else begin
          exp_t e;
          e = (i == 0) ? q0.pop_front() : q1.pop_front();
          chk($sformatf("rdata%0d", i), resp_rdata[i], e.d);
          chk($sformatf("err%0d", i), 32'(resp_err[i]), 32'(e.e));
        end
      end
    end
  end

  always @(negedge clk) if (stall[0]) stall0_cnt++;

  initial begin
    int nlow, nst, nresp, lat;
    rst_n     = 1'b0;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",  32'(req_ready),  32'd0);
    chk("rst_rvalid", 32'(resp_valid), 32'd0);
    chk("rst_rdata0", resp_rdata[0],   32'd0);
    chk("rst_rdata1", resp_rdata[1],   32'd0);
    chk("rst_err",    32'(resp_err),   32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst",  32'(req_ready),  32'd3);
    chk("rvalid_after_rst", 32'(resp_valid), 32'd0);
    @(posedge clk);
    #1;

    // WS=0 store then back-to-back load
    send(0, 1'b1, 8'd5, 32'hDEADBEEF, 4'hF);
    chk("ws0_latency", 32'(resp_valid[0]), 32'd1);
    send(0, 1'b0, 8'd5, 32'd0, 4'h0);

    // Byte strobes
    send(0, 1'b1, 8'd3, 32'h11223344, 4'hF);
    send(0, 1'b1, 8'd3, 32'hAABBCCDD, 4'b0101);
    send(0, 1'b0, 8'd3, 32'd0, 4'h0);
    chk("strobe_model", model[0][3], 32'h11BB33DD);

    // Out-of-range and edge addresses, no-op store
    send(0, 1'b1, 8'd9,   32'h12345678, 4'hF);
    send(0, 1'b1, 8'd210, 32'hFFFFFFFF, 4'hF);
    send(0, 1'b0, 8'd210, 32'd0, 4'h0);
    send(0, 1'b1, 8'd9,   32'hFFFFFFFF, 4'h0);
    send(0, 1'b0, 8'd9,   32'd0, 4'h0);
    send(0, 1'b1, 8'd199, 32'h0BADF00D, 4'hF);
    send(0, 1'b0, 8'd199, 32'd0, 4'h0);
    send(0, 1'b0, 8'd200, 32'd0, 4'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("ws0_stall", 32'(stall0_cnt), 32'd0);

    // WS=3: load held valid through the wait states
    send(1, 1'b1, 8'd5, 32'hCAFEF00D, 4'hF);
    repeat (6) @(posedge clk);
    #1;
    nlow = 0; nst = 0; nresp = 0; lat = 0;
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b0;
    req_addr[1]  = 8'd5;
    @(negedge clk);
    chk("ws3_ready_idle", 32'(req_ready[1]), 32'd1);
    push(1, 32'hCAFEF00D, 1'b0);
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (!req_ready[1]) nlow++;
      if (stall[1]) nst++;
      if (resp_valid[1]) begin
        nresp++;
        if (lat == 0) lat = k;
        req_valid[1] = 1'b0;
      end
    end
    chk("ws3_ready_low", 32'(nlow),  32'd3);
    chk("ws3_stall",     32'(nst),   32'd3);
    chk("ws3_latency",   32'(lat),   32'd4);
    chk("ws3_pulses",    32'(nresp), 32'd1);

    // Reset in second BUSY cycle drops the pending load
    @(posedge clk);
    #1;
    req_valid[1] = 1'b1;
    req_addr[1]  = 8'd5;
    @(negedge clk);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rstmid_ready",  32'(req_ready[1]),  32'd0);
      chk("rstmid_rvalid", 32'(resp_valid[1]), 32'd0);
    end
    chk("rstmid_rdata", resp_rdata[1], 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rstrel_ready", 32'(req_ready[1]), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rstrel_no_resp", 32'(resp_valid[1]), 32'd0);
    end
    @(posedge clk);
    #1;
    send(1, 1'b0, 8'd5, 32'd0, 4'h0);
    repeat (8) @(posedge clk);
    #1;
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
